// File: rtl/grid_cursor_sel.sv
// Cursor selection over a ROWS x COLS board: edge-detected direction buttons move the
// cursor, occupied squares are skipped, and confirm emits a one-cycle pick pulse.
module grid_cursor_sel #(
   parameter int unsigned ROWS      = 2,
   parameter int unsigned COLS      = 4,
   parameter int unsigned N         = ROWS * COLS,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned WRAP_MODE = 0
) (
   input  logic             clk25MHz,
   input  logic             rst,
   input  logic             enable,
   input  logic             up,
   input  logic             down,
   input  logic             right,
   input  logic             left,
   input  logic             confirm,
   input  logic [N-1:0]     occupied,
   output logic [IDX_W-1:0] cursor,
   output logic             cursor_valid,
   output logic             picked,
   output logic [IDX_W-1:0] picked_idx,
   output logic             none_free
);

   localparam int unsigned   W1      = IDX_W + 1;
   localparam logic [W1-1:0] ONE_W   = W1'(1);
   localparam logic [W1-1:0] N_W     = W1'(N);
   localparam logic [W1-1:0] COLS_W  = W1'(COLS);
   localparam logic [W1-1:0] ROWS_W  = W1'(ROWS);
   localparam logic [W1-1:0] SPAN_W  = W1'((ROWS - 1) * COLS);
   localparam logic [W1-1:0] CNT_LIM = W1'(N - 1);

   typedef enum logic [1:0] {IDLE, INIT, MOVE, SKIP} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_RIGHT, D_LEFT} dir_t;

   state_t           state, state_n;
   dir_t             dir_q, dir_n, dir_sel;
   logic [W1-1:0]    cnt, cnt_n;
   logic [4:0]       btn, btn_q, edge_q;
   logic [IDX_W-1:0] cursor_n, picked_idx_n, first_free, tgt;
   logic             valid_n, picked_n, none_free_n, any_free, dir_edge;

   // One neighbour step from square c in direction d, never leaving 0..N-1
   function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] c, input dir_t d);
      logic [W1-1:0] cw, s, r, k;
      cw = W1'(c);
      r  = cw / COLS_W;
      k  = cw % COLS_W;
      s  = cw;
      if (WRAP_MODE == 0) begin
         case (d)
            D_RIGHT: s = (cw + ONE_W == N_W) ? '0 : cw + ONE_W;
            D_LEFT:  s = (cw == '0) ? N_W - ONE_W : cw - ONE_W;
            D_DOWN: begin
               s = cw + COLS_W;
               if (s >= N_W) begin
                  s = s - N_W + ONE_W;
                  if (s >= N_W) s = s - N_W;
               end
            end
            default: begin
               if (cw >= COLS_W) s = cw - COLS_W;
               else begin
                  s = cw + N_W - ONE_W;
                  if (s >= COLS_W) s = s - COLS_W;
                  else             s = s + N_W - COLS_W;
               end
            end
         endcase
      end else begin
         case (d)
            D_RIGHT: s = (k == COLS_W - ONE_W) ? cw - (COLS_W - ONE_W) : cw + ONE_W;
            D_LEFT:  s = (k == '0) ? cw + (COLS_W - ONE_W) : cw - ONE_W;
            D_DOWN:  s = (r == ROWS_W - ONE_W) ? cw - SPAN_W : cw + COLS_W;
            default: s = (r == '0) ? cw + SPAN_W : cw - COLS_W;
         endcase
      end
      return IDX_W'(s);
   endfunction

   assign btn = {up, down, right, left, confirm};

   // Registered rising-edge pulses, one per button
   always_ff @(posedge clk25MHz) begin
      if (rst) begin
         btn_q  <= '0;
         edge_q <= '0;
      end else begin
         btn_q  <= btn;
         edge_q <= btn & ~btn_q;
      end
   end

   always_comb begin
      first_free = '0;
      any_free   = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (!occupied[i]) begin
            first_free = IDX_W'(i);
            any_free   = 1'b1;
         end
      end
   end

   always_comb begin
      dir_edge = |edge_q[4:1];
      if      (edge_q[4]) dir_sel = D_UP;
      else if (edge_q[3]) dir_sel = D_DOWN;
      else if (edge_q[2]) dir_sel = D_RIGHT;
      else                dir_sel = D_LEFT;
   end

   always_ff @(posedge clk25MHz) begin
      if (rst) begin
         state        <= IDLE;
         dir_q        <= D_UP;
         cnt          <= '0;
         cursor       <= '0;
         cursor_valid <= 1'b0;
         picked       <= 1'b0;
         picked_idx   <= '0;
         none_free    <= 1'b0;
      end else begin
         state        <= state_n;
         dir_q        <= dir_n;
         cnt          <= cnt_n;
         cursor       <= cursor_n;
         cursor_valid <= valid_n;
         picked       <= picked_n;
         picked_idx   <= picked_idx_n;
         none_free    <= none_free_n;
      end
   end

   always_comb begin
      state_n      = state;
      dir_n        = dir_q;
      cnt_n        = cnt;
      cursor_n     = cursor;
      valid_n      = 1'b0;
      picked_n     = 1'b0;
      picked_idx_n = picked_idx;
      none_free_n  = none_free;
      tgt          = '0;
      if (!enable) begin
         state_n = IDLE;
         dir_n   = D_UP;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: state_n = INIT;
            INIT: begin
               if (any_free) begin
                  cursor_n    = first_free;
                  state_n     = MOVE;
                  valid_n     = 1'b1;
                  none_free_n = 1'b0;
               end else begin
                  none_free_n = 1'b1;
               end
            end
            MOVE: begin
               valid_n = 1'b1;
               if (occupied[cursor]) begin
                  valid_n = 1'b0;
                  state_n = INIT;
               end else if (edge_q[0]) begin
                  picked_n     = 1'b1;
                  picked_idx_n = cursor;
               end else if (dir_edge) begin
                  tgt      = step(cursor, dir_sel);
                  cursor_n = tgt;
                  if (occupied[tgt]) begin
                     valid_n = 1'b0;
                     state_n = SKIP;
                     dir_n   = dir_sel;
                     cnt_n   = ONE_W;
                  end
               end
            end
            default: begin
               // Walk past occupied squares; give up after N-1 steps and rescan
               if (cnt >= CNT_LIM) begin
                  state_n = INIT;
               end else begin
                  tgt      = step(cursor, dir_q);
                  cursor_n = tgt;
                  cnt_n    = cnt + ONE_W;
                  if (!occupied[tgt]) begin
                     state_n = MOVE;
                     valid_n = 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grid_cursor_sel.sv
// Directed bench for grid_cursor_sel: snake-wrap (u0) and toroidal (u1) instances.
module tb_grid_cursor_sel;

   localparam logic [4:0] B_UP = 5'b10000, B_DN = 5'b01000, B_RT = 5'b00100,
                          B_LT = 5'b00010, B_CF = 5'b00001;

   logic clk25MHz = 1'b0;
   always #20 clk25MHz = ~clk25MHz;

   logic            rst;
   logic [1:0]      en;
   logic [1:0][4:0] btn;
   logic [1:0][7:0] occ;
   logic [2:0]      cur0, cur1, pidx0, pidx1;
   logic            val0, val1, pk0, pk1, nf0, nf1;

   int ncmp = 0;
   int nerr = 0;

   grid_cursor_sel #(.WRAP_MODE(0)) u0 (
      .clk25MHz(clk25MHz), .rst(rst), .enable(en[0]),
      .up(btn[0][4]), .down(btn[0][3]), .right(btn[0][2]), .left(btn[0][1]),
      .confirm(btn[0][0]), .occupied(occ[0]),
      .cursor(cur0), .cursor_valid(val0), .picked(pk0), .picked_idx(pidx0),
      .none_free(nf0));

   grid_cursor_sel #(.WRAP_MODE(1)) u1 (
      .clk25MHz(clk25MHz), .rst(rst), .enable(en[1]),
      .up(btn[1][4]), .down(btn[1][3]), .right(btn[1][2]), .left(btn[1][1]),
      .confirm(btn[1][0]), .occupied(occ[1]),
      .cursor(cur1), .cursor_valid(val1), .picked(pk1), .picked_idx(pidx1),
      .none_free(nf1));

   typedef struct {
      string      name;
      int         mode;
      int         start;
      logic [7:0] occ;
      logic [4:0] btn;
      int         ticks;
      int         exp_cur;
      int         exp_val;
   } vec_t;

   vec_t vecs[17];

   task automatic tick(input int n);
      repeat (n) @(posedge clk25MHz);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; en = '0; btn = '0; occ = '0;
      tick(1);
      rst = 1'b0;
   endtask

   function automatic int get_cur(input int m);
      return (m == 0) ? int'(cur0) : int'(cur1);
   endfunction

   function automatic int get_val(input int m);
      return (m == 0) ? int'(val0) : int'(val1);
   endfunction

   task automatic run_vec(input vec_t v);
      logic [7:0] start_mask;
      do_reset();
      start_mask = 8'((1 << v.start) - 1);
      occ[v.mode] = start_mask;
      en[v.mode]  = 1'b1;
      tick(2);
      chk({v.name, "_start"}, get_cur(v.mode), v.start);
      occ[v.mode] = v.occ;
      btn[v.mode] = v.btn;
      tick(v.ticks);
      chk({v.name, "_cursor"}, get_cur(v.mode), v.exp_cur);
      chk({v.name, "_valid"}, get_val(v.mode), v.exp_val);
      btn[v.mode] = '0;
      en[v.mode]  = 1'b0;
   endtask

   initial begin
      int waited;
      rst = 1'b1; en = '0; btn = '0; occ = '0;

      vecs[0]  = '{"m0_right_wrap",   0, 7, 8'h00, B_RT,        2,  0, 1};
      vecs[1]  = '{"m0_left_wrap",    0, 0, 8'h00, B_LT,        2,  7, 1};
      vecs[2]  = '{"m0_down_wrap",    0, 5, 8'h00, B_DN,        2,  2, 1};
      vecs[3]  = '{"m0_up_wrap",      0, 1, 8'h00, B_UP,        2,  4, 1};
      vecs[4]  = '{"m0_down_plain",   0, 2, 8'h00, B_DN,        2,  6, 1};
      vecs[5]  = '{"m0_hold_right",   0, 7, 8'h00, B_RT,        20, 0, 1};
      vecs[6]  = '{"m0_latency1",     0, 2, 8'h38, B_RT,        1,  2, 1};
      vecs[7]  = '{"m0_skip_t2",      0, 2, 8'h38, B_RT,        2,  3, 0};
      vecs[8]  = '{"m0_skip_t4",      0, 2, 8'h38, B_RT,        4,  5, 0};
      vecs[9]  = '{"m0_skip_settle",  0, 2, 8'h38, B_RT,        5,  6, 1};
      vecs[10] = '{"m0_up_over_left", 0, 4, 8'h00, B_UP | B_LT, 2,  0, 1};
      vecs[11] = '{"m0_down_over_rt", 0, 3, 8'h00, B_DN | B_RT, 2,  7, 1};
      vecs[12] = '{"m1_right_row",    1, 3, 8'h00, B_RT,        2,  0, 1};
      vecs[13] = '{"m1_down_col",     1, 5, 8'h00, B_DN,        2,  1, 1};
      vecs[14] = '{"m1_up_over_left", 1, 4, 8'h00, B_UP | B_LT, 2,  0, 1};
      vecs[15] = '{"m1_left_row",     1, 0, 8'h00, B_LT,        2,  3, 1};
      vecs[16] = '{"m1_up_col",       1, 2, 8'h00, B_UP,        2,  6, 1};

      // Reset values on both instances
      do_reset();
      chk("rst_cursor0", int'(cur0), 0);
      chk("rst_valid0", int'(val0), 0);
      chk("rst_picked0", int'(pk0), 0);
      chk("rst_nf0", int'(nf0), 0);
      chk("rst_cursor1", int'(cur1), 0);
      chk("rst_valid1", int'(val1), 0);

      // Enable picks lowest free square after two cycles
      occ[0] = 8'b0000_0011; en[0] = 1'b1;
      tick(1);
      chk("init_valid_early", int'(val0), 0);
      tick(1);
      chk("init_cursor", int'(cur0), 2);
      chk("init_valid", int'(val0), 1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Confirm pick pulse and mask-driven re-init
      do_reset();
      occ[0] = 8'h3F; en[0] = 1'b1;
      tick(2);
      occ[0] = 8'h00; btn[0] = B_CF;
      tick(1);
      chk("pick_early", int'(pk0), 0);
      tick(1);
      chk("pick_pulse", int'(pk0), 1);
      chk("pick_idx", int'(pidx0), 6);
      tick(1);
      chk("pick_one_cycle", int'(pk0), 0);
      chk("pick_idx_hold", int'(pidx0), 6);
      btn[0] = '0; occ[0] = 8'h40;
      tick(1);
      chk("reinit_valid_drop", int'(val0), 0);
      tick(1);
      chk("reinit_cursor", int'(cur0), 0);
      chk("reinit_valid", int'(val0), 1);

      // Reset in the middle of a skip walk
      occ[0] = 8'h0E; btn[0] = B_RT;
      tick(2);
      chk("skip_mid_cursor", int'(cur0), 1);
      chk("skip_mid_valid", int'(val0), 0);
      rst = 1'b1;
      tick(1);
      chk("rst_skip_cursor", int'(cur0), 0);
      chk("rst_skip_valid", int'(val0), 0);
      chk("rst_skip_picked", int'(pk0), 0);
      chk("rst_skip_pidx", int'(pidx0), 0);
      chk("rst_skip_nf", int'(nf0), 0);
      rst = 1'b0; btn[0] = '0; occ[0] = '0; en[0] = 1'b0;

      // Confirm and direction together: confirm wins
      do_reset();
      occ[0] = 8'h07; en[0] = 1'b1;
      tick(2);
      occ[0] = 8'h00; btn[0] = B_CF | B_RT;
      tick(2);
      chk("cf_dir_picked", int'(pk0), 1);
      chk("cf_dir_pidx", int'(pidx0), 3);
      chk("cf_dir_cursor", int'(cur0), 3);
      btn[0] = '0;

      // Disable drops to idle with cursor held
      en[0] = 1'b0;
      tick(1);
      chk("dis_valid", int'(val0), 0);
      chk("dis_cursor", int'(cur0), 3);

      // All squares occupied, then one freed
      do_reset();
      occ[0] = 8'hFF; en[0] = 1'b1;
      tick(2);
      chk("full_nf", int'(nf0), 1);
      chk("full_valid", int'(val0), 0);
      occ[0] = 8'hEF;
      tick(1);
      chk("freed_cursor", int'(cur0), 4);
      chk("freed_nf", int'(nf0), 0);
      chk("freed_valid", int'(val0), 1);

      // Skip walk exhausts its step budget and falls back to a rescan
      do_reset();
      en[0] = 1'b1;
      tick(2);
      occ[0] = 8'hFE; btn[0] = B_RT;
      tick(2);
      waited = 0;
      while (val0 !== 1'b1 && waited < 40) begin
         tick(1);
         waited++;
      end
      chk("limit_settled", int'(val0 === 1'b1), 1);
      chk("limit_cursor", int'(cur0), 0);
      btn[0] = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
